// File: rtl/csr_fwd_pipe.sv
// CSR write-forwarding pipeline: per-bit speculative CSR views for each stage and per-channel commit masks/data.
// Optional macro CSR_FWD_PIPE_STATS_EN adds a forwarding-event counter (fwd_cnt_o, fwd_cnt_clr_i).
module csr_fwd_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_CSR = 4,
  parameter int unsigned STAGES  = 3,
  localparam int unsigned SELW   = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [STAGES-1:0]         valid_i,
  input  logic [STAGES-1:0]         step_i,
  input  logic [STAGES-1:0]         wen_i,
  input  logic [STAGES*SELW-1:0]    wsel_i,
  input  logic [STAGES*XLEN-1:0]    wmask_i,
  input  logic [STAGES*XLEN-1:0]    wdata_i,
  input  logic [STAGES*SELW-1:0]    rsel_i,
  output logic [STAGES*XLEN-1:0]    rdata_o,
  input  logic [NUM_CSR*XLEN-1:0]   csr_reg_i,
  output logic [NUM_CSR*XLEN-1:0]   commit_wmask_o,
`ifdef CSR_FWD_PIPE_STATS_EN
  input  logic                      fwd_cnt_clr_i,
  output logic [31:0]               fwd_cnt_o,
`endif
  output logic [NUM_CSR*XLEN-1:0]   commit_wdata_o
);

  if (STAGES < 2 || NUM_CSR < 1) begin : g_param_check
    $error("csr_fwd_pipe: STAGES must be >= 2 and NUM_CSR >= 1");
  end

  logic [XLEN-1:0] val_q   [1:STAGES-1][NUM_CSR];
  logic [XLEN-1:0] val_d   [1:STAGES-1][NUM_CSR];
  logic [XLEN-1:0] dirty_q [1:STAGES-1][NUM_CSR];
  logic [XLEN-1:0] dirty_d [1:STAGES-1][NUM_CSR];

  logic [XLEN-1:0] view  [STAGES][NUM_CSR];
  logic [XLEN-1:0] own   [STAGES][NUM_CSR];
  logic [XLEN-1:0] carry [STAGES][NUM_CSR];
  logic [XLEN-1:0] wres  [STAGES][NUM_CSR];
  logic [XLEN-1:0] wmsk  [STAGES][NUM_CSR];

  logic unused_step0;
  assign unused_step0 = step_i[0];

  // Walk older slots first so the youngest valid dirty slot overrides each bit last.
  always_comb begin : view_comb
    logic [XLEN-1:0] v;
    logic [XLEN-1:0] m;
    v = '0;
    m = '0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      for (int unsigned c = 0; c < NUM_CSR; c++) begin
        v = csr_reg_i[c*XLEN +: XLEN];
        for (int unsigned k = STAGES-1; k > j; k--) begin
          m = dirty_q[k][c] & {XLEN{valid_i[k]}};
          v = (v & ~m) | (val_q[k][c] & m);
        end
        view[j][c] = v;
      end
    end
  end

  always_comb begin : own_comb
    for (int unsigned c = 0; c < NUM_CSR; c++) begin
      own[0][c]   = view[0][c];
      carry[0][c] = '0;
    end
    for (int unsigned j = 1; j < STAGES; j++) begin
      for (int unsigned c = 0; c < NUM_CSR; c++) begin
        own[j][c]   = (val_q[j][c] & dirty_q[j][c]) | (view[j][c] & ~dirty_q[j][c]);
        carry[j][c] = dirty_q[j][c];
      end
    end
  end

  always_comb begin : write_comb
    logic hit;
    hit = 1'b0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      for (int unsigned c = 0; c < NUM_CSR; c++) begin
        hit        = wen_i[j] & valid_i[j] & (wsel_i[j*SELW +: SELW] == SELW'(c));
        wmsk[j][c] = hit ? wmask_i[j*XLEN +: XLEN] : '0;
        wres[j][c] = (own[j][c] & ~wmsk[j][c]) | (wdata_i[j*XLEN +: XLEN] & wmsk[j][c]);
      end
    end
  end

  always_comb begin : next_comb
    val_d   = val_q;
    dirty_d = dirty_q;
    for (int unsigned j = 1; j < STAGES; j++) begin
      if (step_i[j]) begin
        for (int unsigned c = 0; c < NUM_CSR; c++) begin
          if (valid_i[j-1]) begin
            val_d[j][c]   = wres[j-1][c];
            dirty_d[j][c] = carry[j-1][c] | wmsk[j-1][c];
          end else begin
            dirty_d[j][c] = '0;
          end
        end
      end
    end
  end

  always_comb begin : out_comb
    rdata_o        = '0;
    commit_wmask_o = '0;
    commit_wdata_o = '0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      for (int unsigned c = 0; c < NUM_CSR; c++) begin
        if (rsel_i[j*SELW +: SELW] == SELW'(c)) rdata_o[j*XLEN +: XLEN] = view[j][c];
      end
    end
    for (int unsigned c = 0; c < NUM_CSR; c++) begin
      commit_wmask_o[c*XLEN +: XLEN] = valid_i[STAGES-1] ?
                                       (dirty_q[STAGES-1][c] | wmsk[STAGES-1][c]) : '0;
      commit_wdata_o[c*XLEN +: XLEN] = wres[STAGES-1][c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 1; j < STAGES; j++) begin
        for (int unsigned c = 0; c < NUM_CSR; c++) begin
          val_q[j][c]   <= '0;
          dirty_q[j][c] <= '0;
        end
      end
    end else if (flush_i) begin
      for (int unsigned j = 1; j < STAGES; j++) begin
        for (int unsigned c = 0; c < NUM_CSR; c++) begin
          val_q[j][c]   <= '0;
          dirty_q[j][c] <= '0;
        end
      end
    end else begin
      val_q   <= val_d;
      dirty_q <= dirty_d;
    end
  end

`ifdef CSR_FWD_PIPE_STATS_EN
  logic        fwd_any;
  logic [31:0] fwd_cnt_q;
  logic [31:0] fwd_cnt_d;

  // Any valid dirty bit on the selected channel means rdata_o[0] takes that bit from a slot.
  always_comb begin
    fwd_any = 1'b0;
    for (int unsigned c = 0; c < NUM_CSR; c++) begin
      if (rsel_i[0 +: SELW] == SELW'(c)) begin
        for (int unsigned k = 1; k < STAGES; k++) begin
          if (valid_i[k] && (|dirty_q[k][c])) fwd_any = 1'b1;
        end
      end
    end
    fwd_cnt_d = fwd_cnt_q;
    if (fwd_cnt_clr_i)                fwd_cnt_d = '0;
    else if (valid_i[0] && fwd_any)   fwd_cnt_d = fwd_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fwd_cnt_q <= '0;
    else     fwd_cnt_q <= fwd_cnt_d;
  end

  assign fwd_cnt_o = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_csr_fwd_pipe.sv
// Self-checking bench for csr_fwd_pipe: directed scenarios followed by random traffic against a per-bit model.
module tb_csr_fwd_pipe;
  localparam int XLEN = 32;
  localparam int NC   = 4;
  localparam int ST   = 3;
  localparam int SW   = 2;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [ST-1:0]      valid, step, wen;
  logic [ST*SW-1:0]   wsel, rsel;
  logic [ST*XLEN-1:0] wmask, wdata, rdata;
  logic [NC*XLEN-1:0] csr, cwm, cwd;
`ifdef CSR_FWD_PIPE_STATS_EN
  logic        clr;
  logic [31:0] cnt;
  logic [31:0] m_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] m_val   [ST][NC];
  logic [31:0] m_dirty [ST][NC];

  always #5 clk = ~clk;

  csr_fwd_pipe #(.XLEN(XLEN), .NUM_CSR(NC), .STAGES(ST)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush),
    .valid_i        (valid),
    .step_i         (step),
    .wen_i          (wen),
    .wsel_i         (wsel),
    .wmask_i        (wmask),
    .wdata_i        (wdata),
    .rsel_i         (rsel),
    .rdata_o        (rdata),
    .csr_reg_i      (csr),
    .commit_wmask_o (cwm),
`ifdef CSR_FWD_PIPE_STATS_EN
    .fwd_cnt_clr_i  (clr),
    .fwd_cnt_o      (cnt),
`endif
    .commit_wdata_o (cwd)
  );

  // Per bit: the first valid dirty slot searching outward from stage j+1, else the architectural bit.
  function automatic logic [31:0] m_view(input int j, input int c, output bit from_slot);
    logic [31:0] r;
    logic [31:0] a;
    bit found;
    a = csr[c*32 +: 32];
    from_slot = 0;
    for (int b = 0; b < 32; b++) begin
      found = 0;
      r[b] = a[b];
      for (int k = j + 1; k < ST; k++) begin
        if (!found && valid[k] && m_dirty[k][c][b]) begin
          r[b] = m_val[k][c][b];
          found = 1;
          from_slot = 1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] m_own(input int j, input int c);
    logic [31:0] v;
    logic [31:0] r;
    bit fs;
    v = m_view(j, c, fs);
    if (j == 0) return v;
    for (int b = 0; b < 32; b++) r[b] = m_dirty[j][c][b] ? m_val[j][c][b] : v[b];
    return r;
  endfunction

  task automatic m_write(input int j, input int c, output logic [31:0] res, output logic [31:0] msk);
    logic [31:0] o;
    logic [31:0] d;
    o = m_own(j, c);
    d = wdata[j*32 +: 32];
    msk = (wen[j] && valid[j] && int'(wsel[j*SW +: SW]) == c) ? wmask[j*32 +: 32] : 32'h0;
    for (int b = 0; b < 32; b++) res[b] = msk[b] ? d[b] : o[b];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int j = 0; j < ST; j++)
      for (int c = 0; c < NC; c++) begin
        m_val[j][c]   = 32'h0;
        m_dirty[j][c] = 32'h0;
      end
`ifdef CSR_FWD_PIPE_STATS_EN
    m_cnt = 32'h0;
`endif
  endtask

  task automatic check_all();
    logic [31:0] r, m;
    bit fs;
    for (int j = 0; j < ST; j++)
      check($sformatf("rdata[%0d]", j), rdata[j*32 +: 32], m_view(j, int'(rsel[j*SW +: SW]), fs));
    for (int c = 0; c < NC; c++) begin
      m_write(ST-1, c, r, m);
      check($sformatf("commit_wmask[%0d]", c), cwm[c*32 +: 32], valid[ST-1] ? (m_dirty[ST-1][c] | m) : 32'h0);
      check($sformatf("commit_wdata[%0d]", c), cwd[c*32 +: 32], r);
    end
`ifdef CSR_FWD_PIPE_STATS_EN
    check("fwd_cnt", cnt, m_cnt);
`endif
  endtask

  // Check outputs mid-cycle, then clock once and advance the model with the same inputs.
  task automatic do_cycle();
    logic [31:0] nv [ST][NC];
    logic [31:0] nd [ST][NC];
    logic [31:0] r, m;
    bit fs;
    logic [31:0] dummy;
    #1;
    check_all();
    nv = m_val;
    nd = m_dirty;
    if (flush) begin
      for (int j = 0; j < ST; j++)
        for (int c = 0; c < NC; c++) begin
          nv[j][c] = 32'h0;
          nd[j][c] = 32'h0;
        end
    end else begin
      for (int j = 1; j < ST; j++) begin
        if (step[j]) begin
          for (int c = 0; c < NC; c++) begin
            if (valid[j-1]) begin
              m_write(j - 1, c, r, m);
              nv[j][c] = r;
              nd[j][c] = ((j - 1 >= 1) ? m_dirty[j-1][c] : 32'h0) | m;
            end else begin
              nd[j][c] = 32'h0;
            end
          end
        end
      end
    end
    dummy = m_view(0, int'(rsel[0 +: SW]), fs);
`ifdef CSR_FWD_PIPE_STATS_EN
    if (clr) m_cnt = 32'h0;
    else if (valid[0] && fs) m_cnt = m_cnt + 32'd1;
`endif
    @(posedge clk);
    m_val   = nv;
    m_dirty = nd;
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; valid = '0; step = '0; wen = '0;
    wsel = '0; rsel = '0; wmask = '0; wdata = '0;
`ifdef CSR_FWD_PIPE_STATS_EN
    clr = 0;
`endif
  endtask

  task automatic set_w(input int j, input logic [1:0] sel, input logic [31:0] mk, input logic [31:0] d);
    wsel[j*SW +: SW] = sel;
    wmask[j*32 +: 32] = mk;
    wdata[j*32 +: 32] = d;
  endtask

  task automatic flush_cycle();
    idle(); flush = 1; do_cycle(); flush = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    csr = {$urandom, $urandom, $urandom, $urandom};
    m_reset();
    @(negedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 0;

    // Forwarding from slot 1 to stage 0
    csr[2*32 +: 32] = 32'h0;
    valid = 3'b001; wen = 3'b001; set_w(0, 2'd2, 32'hFFFF_FFFF, 32'h0000_00A5); step = 3'b010;
    do_cycle();
    idle(); valid = 3'b011; rsel = {2'd0, 2'd2, 2'd2};
    #1;
    check("t1_rdata0", rdata[31:0], 32'h0000_00A5);
    check("t1_rdata1", rdata[63:32], 32'h0000_0000);
    do_cycle();
    flush_cycle();

    // Per-bit merge across two slots
    csr[1*32 +: 32] = 32'hDEAD_BEEF;
    valid = 3'b001; wen = 3'b001; set_w(0, 2'd1, 32'h0000_00FF, 32'h0000_0011); step = 3'b010;
    do_cycle();
    idle(); valid = 3'b011; wen = 3'b001; set_w(0, 2'd1, 32'h0000_FF00, 32'h0000_2200); step = 3'b110;
    do_cycle();
    idle(); valid = 3'b111; rsel = {2'd1, 2'd1, 2'd1};
    #1;
    check("t2_rdata0", rdata[31:0], 32'hDEAD_2211);
    check("t2_rdata1", rdata[63:32], 32'hDEAD_BE11);
    do_cycle();
    flush_cycle();

    // Commit merge, then bubble and hold
    csr[3*32 +: 32] = 32'h1234_5678;
    valid = 3'b001; wen = 3'b001; set_w(0, 2'd3, 32'h0000_00FF, 32'h0000_0042); step = 3'b010;
    do_cycle();
    idle(); valid = 3'b010; step = 3'b100;
    do_cycle();
    idle(); valid = 3'b101; wen = 3'b101; step = 3'b010;
    set_w(0, 2'd3, 32'hFFFF_0000, 32'hABCD_0000);
    set_w(2, 2'd3, 32'hF000_0000, 32'h7000_0000);
    #1;
    check("t3_cwmask3", cwm[127:96], 32'hF000_00FF);
    check("t3_cwdata3_masked", cwd[127:96] & cwm[127:96], 32'h7000_0042);
    for (int c = 0; c < 3; c++) check($sformatf("t3_cwmask_other%0d", c), cwm[c*32 +: 32], 32'h0);
    do_cycle();
    idle(); valid = 3'b011; rsel = {2'd0, 2'd0, 2'd3};
    #1;
    check("t4_slot1_fwd", rdata[31:0], 32'hABCD_5678);
    do_cycle();
    idle(); step = 3'b010;
    do_cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); valid = 3'b110; rsel = {2'd3, 2'd3, 2'd3};
      #1;
      check("t4_hold_rdata0", rdata[31:0], 32'h1234_5642);
      check("t4_hold_rdata1", rdata[63:32], 32'h1234_5642);
      check("t4_hold_cwmask3", cwm[127:96], 32'h0000_00FF);
      do_cycle();
    end
    idle(); valid = 3'b010; rsel = {2'd0, 2'd0, 2'd3};
    #1;
    check("t4_bubble_arch", rdata[31:0], 32'h1234_5678);
    do_cycle();
    flush_cycle();

    // Flush overrides step with a pending write
    valid = 3'b001; wen = 3'b001; set_w(0, 2'd0, 32'hFFFF_FFFF, 32'h1111_1111); step = 3'b010;
    do_cycle();
    valid = 3'b011; wen = 3'b011; set_w(1, 2'd0, 32'h0000_FFFF, 32'h0000_2222); step = 3'b110; flush = 1;
    do_cycle();
    idle(); valid = 3'b111;
    #1;
    for (int c = 0; c < NC; c++) check($sformatf("t5_cwmask%0d", c), cwm[c*32 +: 32], 32'h0);
    check("t5_rdata0", rdata[31:0], csr[31:0]);
    do_cycle();

    // Asynchronous reset between edges
    valid = 3'b001; wen = 3'b001; set_w(0, 2'd1, 32'hFFFF_FFFF, 32'h5A5A_5A5A); step = 3'b010;
    do_cycle();
    idle(); valid = 3'b011; wen = 3'b001; set_w(0, 2'd2, 32'h0000_FFFF, 32'h0000_1234); step = 3'b110;
    do_cycle();
    idle(); valid = 3'b111; rsel = {2'd1, 2'd2, 2'd1};
    #2;
    rst = 1;
    m_reset();
    #1;
    check("t6_rdata0", rdata[31:0], csr[63:32]);
    check("t6_rdata1", rdata[63:32], csr[95:64]);
    for (int c = 0; c < NC; c++) check($sformatf("t6_cwmask%0d", c), cwm[c*32 +: 32], 32'h0);
`ifdef CSR_FWD_PIPE_STATS_EN
    check("t6_fwd_cnt", cnt, 32'h0);
`endif
    #1;
    rst = 0;
    @(negedge clk);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(7) == 0) csr = {$urandom, $urandom, $urandom, $urandom};
      valid = 3'($urandom);
      step  = 3'($urandom);
      wen   = 3'($urandom);
      wsel  = 6'($urandom);
      rsel  = 6'($urandom);
      for (int j = 0; j < ST; j++) begin
        case ($urandom_range(3))
          0: wmask[j*32 +: 32] = 32'hFFFF_FFFF;
          1: wmask[j*32 +: 32] = 32'h0000_00FF << (8 * $urandom_range(3));
          default: wmask[j*32 +: 32] = $urandom;
        endcase
        wdata[j*32 +: 32] = $urandom;
      end
      flush = ($urandom_range(31) == 0);
`ifdef CSR_FWD_PIPE_STATS_EN
      clr = ($urandom_range(15) == 0);
`endif
      do_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
